// File: rtl/axi_stream_header_strip.sv
// -----------------------------------------------------------------------------
// axi_stream_header_strip
//
// Removes the first S bytes (S = byte_strip_cnt + 1, 1..DATA_BYTE_WD) of every
// packet on a byte-oriented AXI-Stream style interface and realigns the rest of
// the packet so that output beats are again fully packed from the MSB byte.
// Byte 0 of a beat sits at data[DATA_WD-1 -: 8]; keep is MSB-aligned contiguous.
//
// Ports
//   clk, rst_n                          clock, asynchronous active-low reset
//   valid_strip/ready_strip,            per-packet strip descriptor
//     byte_strip_cnt                    (strip length minus one)
//   valid_in/ready_in, data_in,         upstream beat
//     keep_in, last_in
//   valid_out/ready_out, data_out,      realigned downstream beat (registered)
//     keep_out, last_out
//   pkt_cnt, drop_cnt                   optional 16-bit packet / dropped-packet
//                                       counters, present only when the macro
//                                       STRIP_PKT_CNT_EN is defined
// -----------------------------------------------------------------------------
module axi_stream_header_strip #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    valid_strip,
    output logic                    ready_strip,
    input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt
`ifdef STRIP_PKT_CNT_EN
    ,
    output logic [15:0]             pkt_cnt,
    output logic [15:0]             drop_cnt
`endif
);

    // Byte counts range 0..DATA_BYTE_WD, one bit wider than the strip count.
    localparam int CW = BYTE_CNT_WD + 1;
    localparam logic [CW-1:0] DBW_C = CW'(DATA_BYTE_WD);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } state_e;

    // Number of set bits in a keep vector.
    function automatic logic [CW-1:0] count_keep(input logic [DATA_BYTE_WD-1:0] k);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            c = c + CW'(k[i]);
        end
        return c;
    endfunction

    // MSB-aligned keep vector with n ones.
    function automatic logic [DATA_BYTE_WD-1:0] keep_of(input logic [CW-1:0] n);
        logic [DATA_BYTE_WD-1:0] k;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            k[DATA_BYTE_WD-1-i] = (CW'(i) < n);
        end
        return k;
    endfunction

    // Zero every byte whose keep bit is clear.
    function automatic logic [DATA_WD-1:0] mask_data(input logic [DATA_WD-1:0]      d,
                                                     input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            m[DATA_WD-1-8*i -: 8] = d[DATA_WD-1-8*i -: 8] & {8{k[DATA_BYTE_WD-1-i]}};
        end
        return m;
    endfunction

    state_e                  state_q, state_d;
    logic [CW-1:0]           s_q, s_d;        // strip length S
    logic [CW-1:0]           r_q, r_d;        // residual byte count (leftover count in FLUSH)
    logic [DATA_WD-1:0]      res_q, res_d;    // residual bytes, MSB-aligned
    logic                    valid_out_q, valid_out_d;
    logic [DATA_WD-1:0]      data_out_q, data_out_d;
    logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
    logic                    last_out_q, last_out_d;

    logic                    out_free_s;
    logic                    accept_in_s;
    logic                    drop_s;
    logic [CW-1:0]           k_s;
    logic [CW:0]             total_s;
    logic [DATA_WD-1:0]      merged_s;
    logic [DATA_WD-1:0]      carry_s;
    logic [DATA_WD-1:0]      first_s;

    assign out_free_s  = !valid_out_q || ready_out;
    assign ready_strip = (state_q == IDLE);
    assign ready_in    = ((state_q == FIRST) || (state_q == STREAM)) && out_free_s;
    assign accept_in_s = valid_in && ready_in;

    // Beat arithmetic shared by the FSM branches.
    always_comb begin
        k_s      = count_keep(keep_in);
        total_s  = {1'b0, r_q} + {1'b0, k_s};
        // Residual bytes followed by the head of the new beat.
        merged_s = res_q | (data_in >> {r_q, 3'b000});
        // Tail of the new beat that did not fit; a shift by the full width gives 0.
        carry_s  = data_in << {DBW_C - r_q, 3'b000};
        // First beat with the S header bytes removed.
        first_s  = data_in << {s_q, 3'b000};
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        r_d         = r_q;
        res_d       = res_q;
        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;
        keep_out_d  = keep_out_q;
        last_out_d  = last_out_q;
        drop_s      = 1'b0;

        if (valid_out_q && ready_out) begin
            valid_out_d = 1'b0;
        end else begin
            valid_out_d = valid_out_q;
        end

        case (state_q)
            IDLE: begin
                if (valid_strip) begin
                    s_d     = {1'b0, byte_strip_cnt} + CW'(1);
                    r_d     = '0;
                    res_d   = '0;
                    state_d = FIRST;
                end else begin
                    state_d = IDLE;
                end
            end
            FIRST: begin
                if (accept_in_s && !last_in) begin
                    res_d   = first_s;
                    r_d     = DBW_C - s_q;
                    state_d = STREAM;
                end else if (accept_in_s) begin
                    res_d   = '0;
                    r_d     = '0;
                    state_d = IDLE;
                    if (k_s > s_q) begin
                        valid_out_d = 1'b1;
                        keep_out_d  = keep_of(k_s - s_q);
                        data_out_d  = mask_data(first_s, keep_of(k_s - s_q));
                        last_out_d  = 1'b1;
                    end else begin
                        // Packet is entirely header: nothing to emit.
                        drop_s = 1'b1;
                    end
                end else begin
                    state_d = FIRST;
                end
            end
            STREAM: begin
                if (accept_in_s && (!last_in || (total_s > {1'b0, DBW_C}))) begin
                    valid_out_d = 1'b1;
                    data_out_d  = merged_s;
                    keep_out_d  = '1;
                    last_out_d  = 1'b0;
                    res_d       = carry_s;
                    if (last_in) begin
                        r_d     = CW'(total_s - {1'b0, DBW_C});
                        state_d = FLUSH;
                    end else begin
                        state_d = STREAM;
                    end
                end else if (accept_in_s) begin
                    valid_out_d = 1'b1;
                    keep_out_d  = keep_of(CW'(total_s));
                    data_out_d  = mask_data(merged_s, keep_of(CW'(total_s)));
                    last_out_d  = 1'b1;
                    res_d       = '0;
                    r_d         = '0;
                    state_d     = IDLE;
                end else begin
                    state_d = STREAM;
                end
            end
            FLUSH: begin
                if (out_free_s) begin
                    valid_out_d = 1'b1;
                    keep_out_d  = keep_of(r_q);
                    data_out_d  = mask_data(res_q, keep_of(r_q));
                    last_out_d  = 1'b1;
                    res_d       = '0;
                    r_d         = '0;
                    state_d     = IDLE;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_q         <= '0;
            r_q         <= '0;
            res_q       <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            keep_out_q  <= '0;
            last_out_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            r_q         <= r_d;
            res_q       <= res_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            keep_out_q  <= keep_out_d;
            last_out_q  <= last_out_d;
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign keep_out  = keep_out_q;
    assign last_out  = last_out_q;

`ifdef STRIP_PKT_CNT_EN
    logic [15:0] pkt_cnt_q;
    logic [15:0] drop_cnt_q;

    // Delivered-packet and dropped-packet counters (wrap naturally).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q  <= 16'd0;
            drop_cnt_q <= 16'd0;
        end else begin
            if (valid_out_q && ready_out && last_out_q) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
            if (drop_s) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_axi_stream_header_strip.sv
module tb_axi_stream_header_strip;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, ready_in, last_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        valid_out, ready_out, last_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        valid_strip, ready_strip;
    logic [1:0]  byte_strip_cnt;
`ifdef STRIP_PKT_CNT_EN
    logic [15:0] pkt_cnt, drop_cnt;
`endif

    axi_stream_header_strip dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
        .keep_in(keep_in), .last_in(last_in),
        .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
        .keep_out(keep_out), .last_out(last_out),
        .valid_strip(valid_strip), .ready_strip(ready_strip),
        .byte_strip_cnt(byte_strip_cnt)
`ifdef STRIP_PKT_CNT_EN
        , .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    typedef struct {
        logic [2:0]       s;
        int               nin;
        logic [2:0][31:0] din;
        logic [2:0][3:0]  kin;
        int               nout;
        logic [2:0][31:0] dout;
        logic [2:0][3:0]  kout;
    } vec_t;

    vec_t  vecs[8];
    beat_t exp_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    int    n_pkts = 0;
    int    n_drop = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard: compare every downstream handshake with the queue head.
    always @(negedge clk) begin
        if (rst_n && valid_out && ready_out) begin
            beat_t e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got %h/%b/%b expected none", data_out, keep_out, last_out);
            end else begin
                e = exp_q.pop_front();
                if ({data_out, keep_out, last_out} !== e) begin
                    n_fail++;
                    $display("FAIL out_beat: got %h/%b/%b expected %h/%b/%b",
                             data_out, keep_out, last_out, e.d, e.k, e.l);
                end
                if (e.l) n_pkts++;
            end
        end
    end

    function automatic vec_t mk(input logic [2:0] s, input int nin,
                                input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] i2,
                                input logic [3:0] k0, input logic [3:0] k1, input logic [3:0] k2,
                                input int nout,
                                input logic [31:0] o0, input logic [31:0] o1, input logic [31:0] o2,
                                input logic [3:0] q0, input logic [3:0] q1, input logic [3:0] q2);
        vec_t v;
        v.s = s; v.nin = nin; v.nout = nout;
        v.din[0] = i0; v.din[1] = i1; v.din[2] = i2;
        v.kin[0] = k0; v.kin[1] = k1; v.kin[2] = k2;
        v.dout[0] = o0; v.dout[1] = o1; v.dout[2] = o2;
        v.kout[0] = q0; v.kout[1] = q1; v.kout[2] = q2;
        return v;
    endfunction

    task automatic send_desc(input logic [2:0] s);
        logic ok = 1'b0;
        valid_strip    = 1'b1;
        byte_strip_cnt = 2'(s - 3'd1);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (ready_strip) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL desc_timeout: got ready_strip=0 expected 1");
        end
        @(posedge clk); #1;
        valid_strip = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        logic ok = 1'b0;
        valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (ready_in) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL beat_timeout: got ready_in=0 expected 1");
        end
        @(posedge clk); #1;
        valid_in = 1'b0; data_in = 32'hDEADBEEF; keep_in = 4'b0000; last_in = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        b.d = d; b.k = k; b.l = l;
        exp_q.push_back(b);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_r029();
        push(32'h22334455, 4'b1111, 1'b0);
        push(32'h66778899, 4'b1111, 1'b0);
        push(32'hAABBCC00, 4'b1110, 1'b1);
        send_desc(3'd1);
        send_beat(32'h11223344, 4'b1111, 1'b0);
        send_beat(32'h55667788, 4'b1111, 1'b0);
        send_beat(32'h99AABBCC, 4'b1111, 1'b1);
        wait_drain();
    endtask

    logic [31:0] held;
    logic        stall_ok;

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        ready_out = 1'b1; valid_strip = 1'b0; byte_strip_cnt = '0;

        vecs[0] = mk(3'd1, 3, 32'h11223344, 32'h55667788, 32'h99AABBCC, 4'hF, 4'hF, 4'hF,
                     3, 32'h22334455, 32'h66778899, 32'hAABBCC00, 4'hF, 4'hF, 4'hE);
        vecs[1] = mk(3'd4, 2, 32'hA0A1A2A3, 32'hB0B1B2B3, 32'h0, 4'hF, 4'hC, 4'h0,
                     1, 32'hB0B10000, 32'h0, 32'h0, 4'hC, 4'h0, 4'h0);
        vecs[2] = mk(3'd2, 2, 32'h01020304, 32'h05060708, 32'h0, 4'hF, 4'hE, 4'h0,
                     2, 32'h03040506, 32'h07000000, 32'h0, 4'hF, 4'h8, 4'h0);
        vecs[3] = mk(3'd3, 1, 32'h01020304, 32'h0, 32'h0, 4'hC, 4'h0, 4'h0,
                     0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0);
        vecs[4] = mk(3'd1, 1, 32'h01020304, 32'h0, 32'h0, 4'hF, 4'h0, 4'h0,
                     1, 32'h02030400, 32'h0, 32'h0, 4'hE, 4'h0, 4'h0);
        vecs[5] = mk(3'd4, 1, 32'hCAFEF00D, 32'h0, 32'h0, 4'hF, 4'h0, 4'h0,
                     0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0);
        vecs[6] = mk(3'd2, 3, 32'h10111213, 32'h20212223, 32'h30313233, 4'hF, 4'hF, 4'h8,
                     2, 32'h12132021, 32'h22233000, 32'h0, 4'hF, 4'hE, 4'h0);
        vecs[7] = mk(3'd3, 2, 32'hAABBCCDD, 32'h11223344, 32'h0, 4'hF, 4'hF, 4'h0,
                     2, 32'hDD112233, 32'h44000000, 32'h0, 4'hF, 4'h8, 4'h0);

        // Reset state, sampled while reset is held.
        #2;
        chk("rst_valid_out", 64'(valid_out), 64'd0);
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_keep_last", 64'({keep_out, last_out}), 64'd0);
        chk("rst_ready_in", 64'(ready_in), 64'd0);
        chk("rst_ready_strip", 64'(ready_strip), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Data offered without a descriptor must wait.
        valid_in = 1'b1; data_in = 32'h12345678; keep_in = 4'hF;
        repeat (2) @(negedge clk);
        chk("idle_ready_in", 64'(ready_in), 64'd0);
        @(posedge clk); #1;
        valid_in = 1'b0;

        // Table-driven packets.
        for (int v = 0; v < 8; v++) begin
            for (int o = 0; o < vecs[v].nout; o++)
                push(vecs[v].dout[o], vecs[v].kout[o], (o == vecs[v].nout - 1));
            if (vecs[v].nout == 0) n_drop++;
            send_desc(vecs[v].s);
            for (int i = 0; i < vecs[v].nin; i++)
                send_beat(vecs[v].din[i], vecs[v].kin[i], (i == vecs[v].nin - 1));
            wait_drain();
        end

        // FLUSH cycle refuses input.
        push(32'h03040506, 4'b1111, 1'b0);
        push(32'h07000000, 4'b1000, 1'b1);
        send_desc(3'd2);
        send_beat(32'h01020304, 4'b1111, 1'b0);
        send_beat(32'h05060708, 4'b1110, 1'b1);
        valid_in = 1'b1; data_in = 32'h0BADF00D; keep_in = 4'hF;
        @(negedge clk);
        chk("flush_ready_in", 64'(ready_in), 64'd0);
        @(posedge clk); #1;
        valid_in = 1'b0;
        wait_drain();

        // Downstream stall mid-packet.
        push(32'h22334455, 4'b1111, 1'b0);
        push(32'h66778899, 4'b1111, 1'b0);
        push(32'hAABBCCDD, 4'b1111, 1'b0);
        push(32'hEEFF1100, 4'b1110, 1'b1);
        fork
            begin
                send_desc(3'd1);
                send_beat(32'h11223344, 4'b1111, 1'b0);
                send_beat(32'h55667788, 4'b1111, 1'b0);
                send_beat(32'h99AABBCC, 4'b1111, 1'b0);
                send_beat(32'hDDEEFF11, 4'b1111, 1'b1);
            end
            begin
                stall_ok = 1'b0;
                for (int c = 0; c < 60; c++) begin
                    @(negedge clk);
                    if (valid_out) begin stall_ok = 1'b1; break; end
                end
                chk("stall_seen_valid", 64'(stall_ok), 64'd1);
                @(posedge clk); #1 ready_out = 1'b0;
                @(negedge clk);
                held = data_out;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    chk("stall_hold", 64'({valid_out, data_out}), 64'({1'b1, held}));
                    chk("stall_ready_in", 64'({ready_in, ready_strip}), 64'd0);
                end
                @(posedge clk); #1 ready_out = 1'b1;
            end
        join
        wait_drain();

        // Reset in the middle of a packet (STREAM state).
        push(32'h22334455, 4'b1111, 1'b0);
        send_desc(3'd1);
        send_beat(32'hFF223344, 4'b1111, 1'b0);
        send_beat(32'h55667788, 4'b1111, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", 64'({valid_out, data_out, keep_out, last_out}), 64'd0);
        chk("midrst_ready", 64'({ready_strip, ready_in}), 64'b10);
        @(posedge clk); #1 rst_n = 1'b1;
        chk("midrst_queue", 64'(exp_q.size()), 64'd0);
        n_pkts = 0;
        n_drop = 0;
        run_r029();

`ifdef STRIP_PKT_CNT_EN
        chk("pkt_cnt", 64'(pkt_cnt), 64'(n_pkts));
        chk("drop_cnt", 64'(drop_cnt), 64'(n_drop));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_stream_header_strip.md
AXI_STREAM_HEADER_STRIP -- requirements
Module: axi_stream_header_strip

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, data bus width in bits.
REQ-002 SHALL have parameter DATA_BYTE_WD, default DATA_WD/8, bytes per beat.
REQ-003 SHALL have parameter BYTE_CNT_WD, default $clog2(DATA_BYTE_WD), strip-count width.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports valid_in/ready_in  input/output  1/1  upstream beat handshake.
REQ-007 SHALL have ports data_in, keep_in, last_in  input  DATA_WD/DATA_BYTE_WD/1  upstream beat; byte 0 at data_in[DATA_WD-1 -: 8]; keep MSB-aligned contiguous.
REQ-008 SHALL have ports valid_out/ready_out  output/input  1/1  downstream beat handshake.
REQ-009 SHALL have ports data_out, keep_out, last_out  output  DATA_WD/DATA_BYTE_WD/1  realigned beat, same byte order and keep rule as input.
REQ-010 SHALL have ports valid_strip/ready_strip  input/output  1/1  per-packet strip descriptor handshake.
REQ-011 SHALL have port byte_strip_cnt  input  BYTE_CNT_WD  strip length minus one: S = byte_strip_cnt+1 bytes, range 1..DATA_BYTE_WD.

Function
REQ-012 SHALL implement FSM states IDLE, FIRST, STREAM, FLUSH.
REQ-013 In IDLE: ready_strip=1, ready_in=0; on valid_strip&ready_strip latch S, go FIRST.
REQ-014 In FIRST/STREAM: ready_in = !valid_out | ready_out; ready_strip=0.
REQ-015 In FIRST, an accepted non-last beat SHALL produce no output; its lower DATA_BYTE_WD-S bytes load the residual register (residual count R = DATA_BYTE_WD-S, may be 0); go STREAM.
REQ-016 In STREAM, each accepted beat SHALL produce one output beat: R residual bytes followed by the first DATA_BYTE_WD-R input bytes; remaining input bytes become the new residual.
REQ-017 For last_in with k valid bytes (k = popcount keep_in): if R+k <= DATA_BYTE_WD, emit one beat with last_out=1, keep_out = R+k MSB-aligned ones, go IDLE.
REQ-018 If R+k > DATA_BYTE_WD, emit a full beat with last_out=0, go FLUSH; FLUSH emits the R+k-DATA_BYTE_WD leftover bytes with last_out=1, then IDLE; ready_in=0 in FLUSH.
REQ-019 A last beat accepted in FIRST with k <= S SHALL be dropped entirely (no output beat); with k > S emit k-S bytes with last_out=1; go IDLE.
REQ-020 Outputs SHALL be registered; latency from accepting the producing input beat to valid_out = 1 cycle.
REQ-021 While valid_out=1 and ready_out=0, data_out/keep_out/last_out SHALL hold stable; no input accepted.
REQ-022 Unused data_out bytes (keep_out=0) SHALL be driven 0.
REQ-023 A descriptor offered outside IDLE SHALL be ignored (ready_strip=0); data offered in IDLE SHALL wait.
REQ-024 Sustained throughput SHALL be one beat per cycle when ready_out=1, except the FLUSH cycle.

Reset
REQ-025 On rst_n low, immediately: state IDLE, valid_out=0, data_out=0, keep_out=0, last_out=0, ready_in=0, ready_strip=1, residual cleared, S cleared.
REQ-026 Reset mid-packet SHALL discard the packet; after release the first transaction accepted is a new descriptor.

Configuration
REQ-027 With macro STRIP_PKT_CNT_EN defined, SHALL add output pkt_cnt (16 bits), reset 0, incrementing on each valid_out&ready_out&last_out, wrapping 16'hFFFF->0, plus output drop_cnt (16 bits) incrementing on each REQ-019 dropped packet.
REQ-028 Without STRIP_PKT_CNT_EN, pkt_cnt and drop_cnt ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 S=1, packet 11223344,55667788,99AABBCC(keep 1111,last), ready_out=1 -> 22334455/1111, 66778899/1111, AABBCC00/1110 last.
REQ-030 S=4, packet A0A1A2A3,B0B1B2B3(keep 1100,last) -> single beat B0B10000/1100 last.
REQ-031 S=2, packet 01020304,05060708(keep 1110,last) -> 03040506/1111, 07000000/1000 last (FLUSH; ready_in=0 that cycle).
REQ-032 S=3, single beat 01020304 keep 1100 last -> no output beat; drop_cnt=1 when STRIP_PKT_CNT_EN.
REQ-033 S=1, 4-beat packet, ready_out low 3 cycles mid-packet -> output held stable, ready_in=0, no byte lost or duplicated.
REQ-034 rst_n pulsed low during STREAM -> outputs 0 same cycle, ready_strip=1; next packet S=1 output correct per REQ-029.
